// File: rtl/prog_mem_ctrl_pkg.sv
// prog_mem_pkg: shared state encoding, NOP constant and sizing helper for the
// loadable program memory (prog_mem_ctrl and prog_mem_array).
package prog_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // All-ones word decodes as NOP; sliced down to the instruction width by users.
    localparam logic [63:0] NOP_WORD = '1;

    // Width of a counter that indexes the beats of one instruction word.
    function automatic int beat_cnt_width(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/prog_mem_ctrl_if.sv
// prog_mem_ctrl_if: CPU fetch port plus byte-stream program loader port.
// master = CPU/loader side, slave = prog_mem_ctrl.
interface prog_mem_ctrl_if #(
    parameter int ADDR_WIDTH  = 6,
    parameter int INSTR_WIDTH = 16,
    parameter int BYTE_WIDTH  = 8
);
    logic [ADDR_WIDTH-1:0]  fetch_addr;
    logic                   fetch_en;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic                   instr_valid;
    logic                   cpu_hold;
    logic                   ld_start;
    logic                   ld_valid;
    logic [BYTE_WIDTH-1:0]  ld_data;
    logic                   ld_last;
    logic                   ld_ready;
    logic                   ld_done;
    logic                   ld_err;
    logic [ADDR_WIDTH:0]    ld_count;

    modport master (
        output fetch_addr, fetch_en, ld_start, ld_valid, ld_data, ld_last,
        input  instr_out, instr_valid, cpu_hold, ld_ready, ld_done, ld_err, ld_count
    );

    modport slave (
        input  fetch_addr, fetch_en, ld_start, ld_valid, ld_data, ld_last,
        output instr_out, instr_valid, cpu_hold, ld_ready, ld_done, ld_err, ld_count
    );
endinterface

// File: rtl/prog_mem_ctrl_array.sv
// prog_mem_array: instruction storage with one write port and one registered
// read port. Words are stored complemented so that a zero-cleared array at
// power-up reads back as all-ones (NOP) without any reset of the array itself.
module prog_mem_array #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_inv [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port: store the complement of the word (array contents survive reset).
    always_ff @(posedge clk) begin
        if (we_i) mem_inv[waddr_i] <= ~wdata_i;
    end

    // Read port: registered output, resets to NOP and holds when no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rdata_q <= '1;
        else if (re_i) rdata_q <= ~mem_inv[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/prog_mem_ctrl.sv
// prog_mem_ctrl: loadable instruction memory. Serves 1-cycle registered fetches
// in IDLE and runs a byte-stream loader FSM (IDLE/LOAD/FILL/DONE) that holds the
// CPU while a new program is written. Define PROG_MEM_FILL_NOP_EN to pad the
// unused tail of memory with NOP words after each load.
module prog_mem_ctrl
    import prog_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int INSTR_WIDTH = 16,
    parameter int BYTE_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst,
    prog_mem_ctrl_if.slave bus
);
    localparam int BPW = INSTR_WIDTH / BYTE_WIDTH;
    localparam int BCW = beat_cnt_width(BPW);
    localparam int SHW = $clog2(INSTR_WIDTH + 1);
    localparam logic [BCW-1:0]      LAST_BEAT = BCW'(BPW - 1);
    localparam logic [ADDR_WIDTH:0] SIZE_C    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [INSTR_WIDTH-1:0] NOP    = NOP_WORD[INSTR_WIDTH-1:0];

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH:0]    wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH:0]    ld_count_q, ld_count_d;
    logic [BCW-1:0]         beat_q, beat_d;
    logic [INSTR_WIDTH-1:0] asm_q, asm_d;
    logic                   ld_err_q, ld_err_d;
    logic                   instr_valid_q;

    logic                   we;
    logic [INSTR_WIDTH-1:0] wdata;
    logic [INSTR_WIDTH-1:0] word_w;
    logic [INSTR_WIDTH-1:0] pad_mask;
    logic [SHW-1:0]         pad_sh;
    logic                   fetch_go;
    logic                   word_end;

    assign fetch_go = (state_q == ST_IDLE) && bus.fetch_en;

    // Next-state and loader datapath: assemble beats into words, pad short final
    // words, discard overflow beats, and sweep NOP words over the tail in FILL.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        ld_count_d = ld_count_q;
        beat_d     = beat_q;
        asm_d      = asm_q;
        ld_err_d   = ld_err_q;
        we         = 1'b0;
        wdata      = NOP;
        word_w     = INSTR_WIDTH'({asm_q, bus.ld_data});
        word_end   = (beat_q == LAST_BEAT);
        pad_sh     = SHW'((BPW - 1 - int'(beat_q)) * BYTE_WIDTH);
        pad_mask   = ~({INSTR_WIDTH{1'b1}} << pad_sh);

        case (state_q)
            ST_IDLE: begin
                if (bus.ld_start) begin
                    state_d    = ST_LOAD;
                    wr_addr_d  = '0;
                    ld_count_d = '0;
                    beat_d     = '0;
                    ld_err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    if (wr_addr_q[ADDR_WIDTH]) begin
                        ld_err_d = 1'b1;
                        if (bus.ld_last) state_d = ST_DONE;
                    end else begin
                        asm_d = word_w;
                        if (word_end || bus.ld_last) begin
                            we         = 1'b1;
                            wdata      = word_end ? word_w : ((word_w << pad_sh) | pad_mask);
                            wr_addr_d  = wr_addr_q + 1'b1;
                            ld_count_d = ld_count_q + 1'b1;
                            beat_d     = '0;
                            if (!word_end) ld_err_d = 1'b1;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                        if (bus.ld_last) begin
`ifdef PROG_MEM_FILL_NOP_EN
                            state_d = (wr_addr_d == SIZE_C) ? ST_DONE : ST_FILL;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
            end
            ST_FILL: begin
`ifdef PROG_MEM_FILL_NOP_EN
                we        = 1'b1;
                wdata     = NOP;
                wr_addr_d = wr_addr_q + 1'b1;
                if (wr_addr_q == LAST_ADDR) state_d = ST_DONE;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and loader registers; reset abandons any load in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            ld_count_q <= '0;
            beat_q     <= '0;
            asm_q      <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            ld_count_q <= ld_count_d;
            beat_q     <= beat_d;
            asm_q      <= asm_d;
            ld_err_q   <= ld_err_d;
        end
    end

    // Fetch-valid flag: set only for a fetch accepted while the loader is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) instr_valid_q <= 1'b0;
        else     instr_valid_q <= fetch_go;
    end

    prog_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (INSTR_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (wr_addr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wdata),
        .re_i    (fetch_go),
        .raddr_i (bus.fetch_addr),
        .rdata_o (bus.instr_out)
    );

    assign bus.instr_valid = instr_valid_q;
    assign bus.cpu_hold    = (state_q != ST_IDLE);
    assign bus.ld_ready    = (state_q == ST_LOAD);
    assign bus.ld_done     = (state_q == ST_DONE);
    assign bus.ld_err      = ld_err_q;
    assign bus.ld_count    = ld_count_q;
endmodule
